// File: rtl/vid_pkg.sv
// Shared constants and types for the video scan-out engine: default raster
// timing, bit-plane indices and the video RAM address layout.
package vid_pkg;

   localparam int unsigned DEF_HTOT = 512;
   localparam int unsigned DEF_VTOT = 312;
   localparam int unsigned DEF_HACT = 256;
   localparam int unsigned DEF_VACT = 248;
   localparam int unsigned DEF_HSS  = 320;
   localparam int unsigned DEF_HSE  = 352;
   localparam int unsigned DEF_VSS  = 270;
   localparam int unsigned DEF_VSE  = 273;

   localparam int unsigned PLANE_W = 2;
   localparam int unsigned ROW_W   = 8;
   localparam int unsigned COL_W   = 5;
   localparam int unsigned ADDR_W  = PLANE_W + ROW_W + COL_W;

   localparam logic [PLANE_W-1:0] PL_B = 2'd0;
   localparam logic [PLANE_W-1:0] PL_R = 2'd1;
   localparam logic [PLANE_W-1:0] PL_G = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_P0,
      S_P1,
      S_P2,
      S_CAP
   } fetch_state_t;

   function automatic logic [ADDR_W-1:0] vram_addr(
      input logic [PLANE_W-1:0] plane,
      input logic [ROW_W-1:0]   row,
      input logic [COL_W-1:0]   col
   );
      return {plane, row, col};
   endfunction

endpackage

// File: rtl/vid_timing.sv
// Raster counters, registered sync/blank, and the cell fetch trigger with
// the target row/column of the cell to be fetched next.
module vid_timing
   import vid_pkg::*;
#(
   parameter int unsigned HTOT = DEF_HTOT,
   parameter int unsigned VTOT = DEF_VTOT,
   parameter int unsigned HACT = DEF_HACT,
   parameter int unsigned VACT = DEF_VACT,
   parameter int unsigned HSS  = DEF_HSS,
   parameter int unsigned HSE  = DEF_HSE,
   parameter int unsigned VSS  = DEF_VSS,
   parameter int unsigned VSE  = DEF_VSE
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ce,
   output logic [8:0]       hc,
   output logic [8:0]       vc,
   output logic             hsync,
   output logic             vsync,
   output logic             blank,
   output logic             pix_active,
   output logic             cell_start,
   output logic             trig,
   output logic [ROW_W-1:0] trow,
   output logic [COL_W-1:0] tcol
);

   logic [8:0] hc_nxt;
   logic [8:0] vc_nxt;
   logic [9:0] tgt_col;
   logic [8:0] tgt_line;

   always_comb begin
      hc_nxt = hc + 9'd1;
      vc_nxt = vc;
      if (hc == 9'(HTOT - 1)) begin
         hc_nxt = '0;
         vc_nxt = (vc == 9'(VTOT - 1)) ? '0 : vc + 9'd1;
      end
   end

   // Decode is done on the column the next ce moves to, so the fetch for
   // the following cell starts on the same edge the current cell loads.
   always_comb begin
      tgt_col  = 10'(hc_nxt) + 10'd8;
      tgt_line = vc_nxt;
      if (tgt_col == 10'(HTOT)) begin
         tgt_col  = '0;
         tgt_line = (vc_nxt == 9'(VTOT - 1)) ? '0 : vc_nxt + 9'd1;
      end
      cell_start = (hc_nxt[2:0] == 3'd0);
      pix_active = (hc_nxt < 9'(HACT)) && (vc_nxt < 9'(VACT));
      trig       = ce && cell_start && (tgt_col < 10'(HACT)) && (tgt_line < 9'(VACT));
      trow       = tgt_line[ROW_W-1:0];
      tcol       = tgt_col[COL_W+2:3];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         hc    <= '0;
         vc    <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
         blank <= 1'b1;
      end else if (ce) begin
         hc    <= hc_nxt;
         vc    <= vc_nxt;
         hsync <= !((hc_nxt >= 9'(HSS)) && (hc_nxt < 9'(HSE)));
         vsync <= !((vc_nxt >= 9'(VSS)) && (vc_nxt < 9'(VSE)));
         blank <= !pix_active;
      end
   end

endmodule

// File: rtl/vid_fetch.sv
// Raster scan-out engine: fetches the blue, red and green planes of each
// 8-pixel cell from video RAM and serialises them into 1-bit RGB pixels.
module vid_fetch
   import vid_pkg::*;
#(
   parameter int unsigned HTOT = DEF_HTOT,
   parameter int unsigned VTOT = DEF_VTOT,
   parameter int unsigned HACT = DEF_HACT,
   parameter int unsigned VACT = DEF_VACT,
   parameter int unsigned HSS  = DEF_HSS,
   parameter int unsigned HSE  = DEF_HSE,
   parameter int unsigned VSS  = DEF_VSS,
   parameter int unsigned VSE  = DEF_VSE
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ce,
   output logic [ADDR_W-1:0] a,
   input  logic [7:0]        q,
   output logic              r,
   output logic              g,
   output logic              b,
   output logic              blank,
   output logic              hsync,
   output logic              vsync,
   output logic [8:0]        hc,
   output logic [8:0]        vc
);

   logic             pix_active;
   logic             cell_start;
   logic             trig;
   logic [ROW_W-1:0] trow;
   logic [COL_W-1:0] tcol;

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] a_nxt;
   logic              cap_b;
   logic              cap_r;
   logic              cap_g;
   logic [7:0]        hold_b;
   logic [7:0]        hold_r;
   logic [7:0]        hold_g;
   logic [7:0]        sh_b;
   logic [7:0]        sh_r;
   logic [7:0]        sh_g;

   vid_timing #(
      .HTOT(HTOT),
      .VTOT(VTOT),
      .HACT(HACT),
      .VACT(VACT),
      .HSS (HSS),
      .HSE (HSE),
      .VSS (VSS),
      .VSE (VSE)
   ) u_timing (
      .clock     (clock),
      .reset     (reset),
      .ce        (ce),
      .hc        (hc),
      .vc        (vc),
      .hsync     (hsync),
      .vsync     (vsync),
      .blank     (blank),
      .pix_active(pix_active),
      .cell_start(cell_start),
      .trig      (trig),
      .trow      (trow),
      .tcol      (tcol)
   );

   always_ff @(posedge clock) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Row/column of the cell in flight are carried in a's low bits, so only
   // the plane field changes between the three reads.
   always_comb begin
      state_nxt = state;
      a_nxt     = a;
      cap_b     = 1'b0;
      cap_r     = 1'b0;
      cap_g     = 1'b0;
      case (state)
         S_IDLE: begin
            if (trig) begin
               state_nxt = S_P0;
               a_nxt     = vram_addr(PL_B, trow, tcol);
            end
         end
         S_P0: begin
            state_nxt = S_P1;
            a_nxt     = {PL_R, a[ROW_W+COL_W-1:0]};
            cap_b     = 1'b1;
         end
         S_P1: begin
            state_nxt = S_P2;
            a_nxt     = {PL_G, a[ROW_W+COL_W-1:0]};
            cap_r     = 1'b1;
         end
         S_P2: begin
            state_nxt = S_CAP;
            cap_g     = 1'b1;
         end
         S_CAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         a      <= '0;
         hold_b <= '0;
         hold_r <= '0;
         hold_g <= '0;
      end else begin
         a <= a_nxt;
         if (cap_b) hold_b <= q;
         if (cap_r) hold_r <= q;
         if (cap_g) hold_g <= q;
      end
   end

   // Shifters keep only the pixels not yet shown; the output register
   // holds the current one, so bit 7 of a shifter is always the next pixel.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sh_b <= '0;
         sh_r <= '0;
         sh_g <= '0;
         r    <= 1'b0;
         g    <= 1'b0;
         b    <= 1'b0;
      end else if (ce) begin
         if (!pix_active) begin
            r <= 1'b0;
            g <= 1'b0;
            b <= 1'b0;
         end else if (cell_start) begin
            sh_b <= {hold_b[6:0], 1'b0};
            sh_r <= {hold_r[6:0], 1'b0};
            sh_g <= {hold_g[6:0], 1'b0};
            b    <= hold_b[7];
            r    <= hold_r[7];
            g    <= hold_g[7];
         end else begin
            sh_b <= {sh_b[6:0], 1'b0};
            sh_r <= {sh_r[6:0], 1'b0};
            sh_g <= {sh_g[6:0], 1'b0};
            b    <= sh_b[7];
            r    <= sh_r[7];
            g    <= sh_g[7];
         end
      end
   end

   fetch_overlap: assert property (@(posedge clock) disable iff (!reset)
      !(trig && (state != S_IDLE)));

endmodule

// File: tb/tb_vid_fetch.sv
// Bench for vid_fetch with a reduced raster; the video RAM model returns the
// byte at the address issued on the previous edge.
module tb_vid_fetch;

   localparam int unsigned HTOT  = 64;
   localparam int unsigned VTOT  = 40;
   localparam int unsigned HACT  = 32;
   localparam int unsigned VACT  = 24;
   localparam int unsigned HSS   = 40;
   localparam int unsigned HSE   = 48;
   localparam int unsigned VSS   = 30;
   localparam int unsigned VSE   = 33;
   localparam int unsigned FRAME = HTOT * VTOT;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ce    = 1'b0;
   logic [14:0] a;
   logic [7:0]  q;
   logic        r, g, b, blank, hsync, vsync;
   logic [8:0]  hc, vc;

   logic [7:0]  mem [0:32767];
   int unsigned vectors = 0;
   int unsigned errors  = 0;
   int unsigned n_ce    = 0;

   vid_fetch #(
      .HTOT(HTOT), .VTOT(VTOT), .HACT(HACT), .VACT(VACT),
      .HSS(HSS), .HSE(HSE), .VSS(VSS), .VSE(VSE)
   ) dut (
      .clock(clock), .reset(reset), .ce(ce), .a(a), .q(q),
      .r(r), .g(g), .b(b), .blank(blank), .hsync(hsync), .vsync(vsync),
      .hc(hc), .vc(vc)
   );

   always #5 clock = ~clock;
   assign q = mem[a];

   // Expected {r,g,b} for the n-th ce after reset release. Cells 0 and 1 of
   // the first line after reset are never fetched and show black.
   function automatic logic [2:0] exp_rgb(input int unsigned n);
      int unsigned h, v, bi;
      logic [14:0] base;
      logic [7:0]  pb, pr, pg;
      h = n % HTOT;
      v = (n / HTOT) % VTOT;
      if (!(h < HACT && v < VACT)) return 3'b000;
      if (n < HTOT && h < 16) return 3'b000;
      base = 15'((v % 256) * 32 + h / 8);
      pb = mem[base];
      pr = mem[base + 15'h2000];
      pg = mem[base + 15'h4000];
      bi = 7 - (h % 8);
      return {pr[bi], pg[bi], pb[bi]};
   endfunction

   function automatic void fill_random();
      for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
   endfunction

   function automatic void clear_mem();
      for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
   endfunction

   task automatic tick(input logic en);
      ce = en;
      @(posedge clock);
      #1;
      if (en && reset) n_ce++;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      ce    = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      n_ce  = 0;
   endtask

   task automatic test_reset();
      fill_random();
      reset = 1'b0;
      ce    = 1'b1;
      repeat (3) begin @(posedge clock); #1; end
      vectors++; if (hc !== 9'd0) begin errors++; $display("FAIL reset_hc got %0d want 0", hc); end
      vectors++; if (vc !== 9'd0) begin errors++; $display("FAIL reset_vc got %0d want 0", vc); end
      vectors++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b want 1", blank); end
      vectors++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync); end
      vectors++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync); end
      vectors++; if ({r, g, b} !== 3'b000) begin errors++; $display("FAIL reset_rgb got %b want 000", {r, g, b}); end
      vectors++; if (a !== 15'h0000) begin errors++; $display("FAIL reset_a got %h want 0000", a); end
      reset = 1'b1;
      ce    = 1'b0;
      n_ce  = 0;
   endtask

   task automatic test_timing();
      int unsigned h, v, hs_low, blank_low;
      fill_random();
      do_reset();
      hs_low    = 0;
      blank_low = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         tick(1'b1);
         h = n_ce % HTOT;
         v = (n_ce / HTOT) % VTOT;
         vectors++;
         if (hc !== 9'(h) || vc !== 9'(v)) begin
            errors++; $display("FAIL timing_pos n=%0d got %0d/%0d want %0d/%0d", n_ce, hc, vc, h, v);
         end
         vectors++;
         if (blank !== ((h < HACT && v < VACT) ? 1'b0 : 1'b1)) begin
            errors++; $display("FAIL timing_blank h=%0d v=%0d got %b", h, v, blank);
         end
         vectors++;
         if (hsync !== ((h >= HSS && h < HSE) ? 1'b0 : 1'b1)) begin
            errors++; $display("FAIL timing_hsync h=%0d v=%0d got %b", h, v, hsync);
         end
         vectors++;
         if (vsync !== ((v >= VSS && v < VSE) ? 1'b0 : 1'b1)) begin
            errors++; $display("FAIL timing_vsync h=%0d v=%0d got %b", h, v, vsync);
         end
         vectors++;
         if ({r, g, b} !== exp_rgb(n_ce)) begin
            errors++; $display("FAIL timing_rgb h=%0d v=%0d got %b want %b", h, v, {r, g, b}, exp_rgb(n_ce));
         end
         vectors++;
         if (a[12:5] >= 8'(VACT) || a[4:0] >= 5'(HACT / 8)) begin
            errors++; $display("FAIL fetch_range got a=%h want row<%0d col<%0d", a, VACT, HACT / 8);
         end
         if (hsync === 1'b0) hs_low++;
         if (h == HTOT - 1) begin
            vectors++;
            if (hs_low != HSE - HSS) begin
               errors++; $display("FAIL hsync_width line=%0d got %0d want %0d", v, hs_low, HSE - HSS);
            end
            hs_low = 0;
         end
         if (n_ce >= FRAME && n_ce < 2 * FRAME && blank === 1'b0) blank_low++;
         if (n_ce == 2 * FRAME - 1) begin
            vectors++;
            if (blank_low != HACT * VACT) begin
               errors++; $display("FAIL active_count got %0d want %0d", blank_low, HACT * VACT);
            end
         end
         repeat (3) tick(1'b0);
      end
   endtask

   task automatic test_plane_decode();
      int unsigned h;
      logic [2:0] want;
      clear_mem();
      mem[15'h0000] = 8'h80;
      mem[15'h2000] = 8'h40;
      mem[15'h4000] = 8'h20;
      do_reset();
      while (n_ce < FRAME + HACT) begin
         tick(1'b1);
         if (n_ce >= FRAME) begin
            h    = n_ce - FRAME;
            want = (h == 0) ? 3'b001 : (h == 1) ? 3'b100 : (h == 2) ? 3'b010 : 3'b000;
            vectors++;
            if ({r, g, b} !== want) begin
               errors++; $display("FAIL plane_decode px=%0d got %b want %b", h, {r, g, b}, want);
            end
         end
      end
   endtask

   task automatic test_address_seq();
      bit found;
      fill_random();
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 8 * HTOT * 4 && !found; i++) begin
         tick(i % 4 == 0);
         if (a === 15'h00A3) found = 1'b1;
      end
      vectors++;
      if (!found) begin
         errors++; $display("FAIL addr_seq timeout got a=%h want 00a3", a);
      end else begin
         vectors++;
         if (hc !== 9'd16 || vc !== 9'd5) begin
            errors++; $display("FAIL addr_seq_when got %0d/%0d want 16/5", hc, vc);
         end
         tick(1'b0);
         vectors++; if (a !== 15'h20A3) begin errors++; $display("FAIL addr_seq_r got %h want 20a3", a); end
         tick(1'b0);
         vectors++; if (a !== 15'h40A3) begin errors++; $display("FAIL addr_seq_g got %h want 40a3", a); end
         tick(1'b0);
         while (n_ce < 5 * HTOT + 32) begin
            tick(1'b1);
            if (n_ce >= 5 * HTOT + 24) begin
               vectors++;
               if ({r, g, b} !== exp_rgb(n_ce)) begin
                  errors++; $display("FAIL addr_seq_px n=%0d got %b want %b", n_ce, {r, g, b}, exp_rgb(n_ce));
               end
            end
            repeat (3) tick(1'b0);
         end
      end
   endtask

   task automatic test_line_wrap();
      bit found;
      clear_mem();
      mem[15'h0020] = 8'hFF;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 4 * HTOT && !found; i++) begin
         tick(i % 2 == 0);
         if (a === 15'h0020) found = 1'b1;
      end
      vectors++;
      if (!found) begin
         errors++; $display("FAIL wrap_fetch timeout got a=%h want 0020", a);
      end else begin
         vectors++;
         if (hc !== 9'(HTOT - 8) || vc !== 9'd0) begin
            errors++; $display("FAIL wrap_fetch_when got %0d/%0d want %0d/0", hc, vc, HTOT - 8);
         end
         while (n_ce < HTOT + 7) begin
            tick(1'b0);
            tick(1'b1);
            if (n_ce >= HTOT) begin
               vectors++;
               if ({r, g, b} !== 3'b001) begin
                  errors++; $display("FAIL wrap_px n=%0d got %b want 001", n_ce, {r, g, b});
               end
            end
         end
      end
   endtask

   task automatic test_ce_every_clock();
      int unsigned h, v;
      fill_random();
      do_reset();
      for (int k = 0; k < 2 * FRAME; k++) begin
         tick(1'b1);
         h = n_ce % HTOT;
         v = (n_ce / HTOT) % VTOT;
         vectors++;
         if ({r, g, b} !== exp_rgb(n_ce) || blank !== ((h < HACT && v < VACT) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL fast_px h=%0d v=%0d got %b/%b want %b", h, v, {r, g, b}, blank, exp_rgb(n_ce));
         end
         if (a[12:5] >= 8'(VACT) || a[4:0] >= 5'(HACT / 8)) begin
            vectors++; errors++;
            $display("FAIL fast_fetch_range got a=%h want row<%0d col<%0d", a, VACT, HACT / 8);
         end
      end
   endtask

   task automatic test_reset_mid_fetch();
      bit found;
      fill_random();
      do_reset();
      for (int i = 0; i < 4 * HTOT; i++) tick(i % 2 == 0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick(i % 2 == 0);
         if (a[14:13] === 2'd1) found = 1'b1;
      end
      vectors++;
      if (!found) begin errors++; $display("FAIL midreset_wait got a=%h want plane 1", a); end
      reset = 1'b0;
      ce    = 1'b1;
      @(posedge clock);
      #1;
      vectors++; if (hc !== 9'd0 || vc !== 9'd0) begin errors++; $display("FAIL midreset_pos got %0d/%0d want 0/0", hc, vc); end
      vectors++; if ({r, g, b} !== 3'b000) begin errors++; $display("FAIL midreset_rgb got %b want 000", {r, g, b}); end
      vectors++; if (blank !== 1'b1) begin errors++; $display("FAIL midreset_blank got %b want 1", blank); end
      reset = 1'b1;
      ce    = 1'b0;
      n_ce  = 0;
      while (n_ce < FRAME + HACT) begin
         tick(1'b1);
         vectors++;
         if (hc !== 9'(n_ce % HTOT) || {r, g, b} !== exp_rgb(n_ce)) begin
            errors++;
            $display("FAIL midreset_px n=%0d got hc=%0d rgb=%b want hc=%0d rgb=%b",
                     n_ce, hc, {r, g, b}, n_ce % HTOT, exp_rgb(n_ce));
         end
         tick(1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_plane_decode();
      test_address_seq();
      test_line_wrap();
      test_ce_every_clock();
      test_reset_mid_fetch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/vid_fetch.md
Name: vid_fetch

Overview:
- Raster scan-out engine. Reads the video bitmap out of the read-only port (address out, data back) of the shared dual-port video RAM.
- Generates its own raster timing and fetches three bit-planes (blue, red, green) per 8-pixel cell. It serializes them into 1-bit RGB pixels with sync and blank.
- Sits between the video RAM and the board video output/scaler. The CPU owns the RAM's other port.

Parameters:
- HTOT, 512, pixel clocks per line (multiple of 8)
- VTOT, 312, lines per frame
- HACT, 256, active pixels per line (multiple of 8, < HTOT)
- VACT, 248, active lines per frame
- HSS, 320, hsync start column; HSE, 352, hsync end column (exclusive)
- VSS, 270, vsync start line; VSE, 273, vsync end line (exclusive)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- ce  in  1  pixel clock enable, one-clock pulse, at least 1 clock apart
- a  out  15  video RAM read address = {plane[1:0], row[7:0], col[4:0]}
- q  in  8  video RAM read data, valid exactly 1 clock after a
- r, g, b  out  1 each  pixel colour bits
- blank  out  1  high outside active area
- hsync, vsync  out  1 each  active-low syncs
- hc  out  9  current column; vc  out  9  current line (for light-pen/interrupt use)

Behaviour:
- Reset (reset=0 at a clock edge): hc=0, vc=0, fetch FSM in IDLE, a=0, r=g=b=0, blank=1, hsync=vsync=1, shifters and holding registers cleared. Reset mid-fetch aborts the fetch; nothing is retained.
- Counters advance only on ce. hc wraps HTOT-1 -> 0 and then increments vc. vc wraps VTOT-1 -> 0.
- Active area: hc<HACT and vc<VACT.
- hsync=0 when HSS<=hc<HSE. vsync=0 when VSS<=vc<VSE.
- All of r/g/b/blank/hsync/vsync are registered and update on the clock edge where ce=1. Output latency is 1 clock after the ce that sets hc to the column.
- Fetch trigger, on a ce that moves hc to value H with H[2:0]==0:
  - Fetches the cell at column H+8. If H+8 == HTOT, it fetches column 0 of the next line (vc+1, wrapped).
  - Fires only if the target column is < HACT and the target line is < VACT.
  - So cell 0 is prefetched at H=HTOT-8, and there is no fetch for H=HACT-8.
- Fetch FSM runs on clock, not ce:
  - IDLE -> P0: a={0,row,col}
  - P0 -> P1: a={1,row,col}; holdB<=q
  - P1 -> P2: a={2,row,col}; holdR<=q
  - P2 -> CAP: holdG<=q
  - CAP -> IDLE
  - Total 4 clocks, which is always less than 8 ce periods.
  - row=target line[7:0]; col=target column[7:3].
  - A trigger while the FSM is not in IDLE is a protocol violation. The FSM ignores it; the simulation assertion flags it.
- Shifter load: on a ce with new hc in active area and hc[2:0]==0, the B/R/G shift regs load from the hold regs and the outputs present bit 7 (MSB = leftmost pixel). On the other active ce cycles, the shifters shift left and the outputs present the next bit.
- Outside active area: r=g=b=0, blank=1. Shifters do not shift.
- a holds its last value while IDLE.
- ce held high every clock is legal. The fetch still completes 4 clocks before the next load.

Decomposition:
- Package vid_pkg holds:
  - default timing constants (HTOT..VSE)
  - plane index constants PL_B=0, PL_R=1, PL_G=2
  - address field widths (plane 2, row 8, col 5)
- One natural sub-module, vid_timing: hc/vc counters, sync, active flag, fetch-trigger and target row/col generation.
- vid_fetch instantiates vid_timing and holds the fetch FSM, hold registers and shifters.

Test Plan:
- Timing: reset, ce every 4 clocks for 2 frames -> hsync low for 32 ce per line at hc 320..351; vsync low for lines 270..272; blank low for exactly 256x248 pixels per frame.
- Plane decode: RAM model with plane0[0]=8'h80, plane1[0]=8'h40, plane2[0]=8'h20, rest 0 -> line 0 pixel 0 r,g,b=0,0,1; pixel 1 = 1,0,0; pixel 2 = 0,1,0; pixels 3..255 = 0.
- Address sequence: line 5, cell 3 -> a issues 0x00A3, 0x20A3, 0x40A3 on consecutive clocks; q captured 1 clock later each.
- Line wrap prefetch: plane0 byte row 1 col 0 = 8'hFF -> a=0x0020 issued at hc=504 of line 0; line 1 pixels 0..7 have b=1. Line 247 produces no fetch targeting line 248.
- ce every clock: same image as the ce/4 case, no assertion fired, fetch completes before each load.
- Reset mid-fetch: drop reset in state P1 for 1 clock -> next clock outputs r=g=b=0, blank=1, hc=vc=0. After release, frame restarts cleanly with correct pixels on line 0.
